// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the NPC memory-port arbiter.
package ysyx_25020047_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25020047_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module ysyx_25020047_rr_pick2
    import ysyx_25020047_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // grant[0] = IFU, grant[1] = LSU
    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
            grant = (last_grant == OWN_IFU) ? 2'b10 : 2'b01;
        end else if (lsu_valid) begin
            grant = 2'b10;
        end else if (ifu_valid) begin
            grant = 2'b01;
        end
    end

endmodule

// File: rtl/ysyx_25020047_mem_arbiter.sv
// Shares the single core memory port between IFU and LSU, one outstanding transaction at a time.
module ysyx_25020047_mem_arbiter
    import ysyx_25020047_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_rsp_valid,
    output logic [DATA_W-1:0]   ifu_rsp_data,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_rsp_valid,
    output logic [DATA_W-1:0]   lsu_rsp_data,
    output logic                lsu_rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_e          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic                ifu_rsp_valid_q, ifu_rsp_valid_d;
    logic                lsu_rsp_valid_q, lsu_rsp_valid_d;
    logic [1:0]          grant;

    ysyx_25020047_rr_pick2 u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign ifu_req_ready = (state_q == ST_IDLE) && grant[0];
    assign lsu_req_ready = (state_q == ST_IDLE) && grant[1];

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        rsp_data_d      = rsp_data_q;
        rsp_err_d       = rsp_err_q;
        cnt_d           = cnt_q;
        mem_req_valid_d = mem_req_valid_q;
        ifu_rsp_valid_d = 1'b0;
        lsu_rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant[1]) begin
                    owner_d         = OWN_LSU;
                    last_grant_d    = OWN_LSU;
                    addr_d          = lsu_addr;
                    wen_d           = lsu_wen;
                    wdata_d         = lsu_wdata;
                    wmask_d         = lsu_wmask;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end else if (grant[0]) begin
                    owner_d         = OWN_IFU;
                    last_grant_d    = OWN_IFU;
                    addr_d          = ifu_addr;
                    wen_d           = 1'b0;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = '0;
                    state_d         = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response wins over a timeout landing in the same cycle.
                if (mem_rsp_valid) begin
                    rsp_data_d      = mem_rsp_data;
                    rsp_err_d       = 1'b0;
                    ifu_rsp_valid_d = (owner_q == OWN_IFU);
                    lsu_rsp_valid_d = (owner_q == OWN_LSU);
                    state_d         = ST_RESP;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
                    rsp_data_d      = '0;
                    rsp_err_d       = 1'b1;
                    ifu_rsp_valid_d = (owner_q == OWN_IFU);
                    lsu_rsp_valid_d = (owner_q == OWN_LSU);
                    state_d         = ST_RESP;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_IFU;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            rsp_data_q      <= '0;
            rsp_err_q       <= 1'b0;
            cnt_q           <= '0;
            mem_req_valid_q <= 1'b0;
            ifu_rsp_valid_q <= 1'b0;
            lsu_rsp_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            rsp_data_q      <= rsp_data_d;
            rsp_err_q       <= rsp_err_d;
            cnt_q           <= cnt_d;
            mem_req_valid_q <= mem_req_valid_d;
            ifu_rsp_valid_q <= ifu_rsp_valid_d;
            lsu_rsp_valid_q <= lsu_rsp_valid_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Response payload is only visible on the owner's side during its strobe.
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_data  = ifu_rsp_valid_q ? rsp_data_q : '0;
    assign ifu_rsp_err   = ifu_rsp_valid_q & rsp_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_data  = lsu_rsp_valid_q ? rsp_data_q : '0;
    assign lsu_rsp_err   = lsu_rsp_valid_q & rsp_err_q;

endmodule

// File: tb/tb_ysyx_25020047_mem_arbiter.sv
// Directed testbench for the IFU/LSU memory-port arbiter.
module tb_ysyx_25020047_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;

    int total = 0;
    int bad   = 0;

    ysyx_25020047_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 1'b0;
        ifu_addr      = '0;
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    // Accepts the request in the current ISSUE cycle, responds next cycle, samples the RESP cycle.
    task automatic mem_serve(input logic [31:0] rdata, output logic [31:0] addr_seen,
                             output logic lsu_won, output logic [31:0] data_seen,
                             output logic good);
        good      = mem_req_valid;
        addr_seen = mem_addr;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rdata;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        good      = good && (ifu_rsp_valid ^ lsu_rsp_valid) && !ifu_rsp_err && !lsu_rsp_err;
        lsu_won   = lsu_rsp_valid;
        data_seen = lsu_rsp_valid ? lsu_rsp_data : ifu_rsp_data;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #3;
        total++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ready: got %b want 000", {ifu_req_ready, lsu_req_ready, mem_req_valid});
        end
        total++;
        if ({ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_rsp: got %b want 0000", {ifu_rsp_valid, ifu_rsp_err, lsu_rsp_valid, lsu_rsp_err});
        end
        total++;
        if ({mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data} !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%h wen=%b wdata=%h wmask=%h ifu=%h lsu=%h want all 0",
                     mem_addr, mem_wen, mem_wdata, mem_wmask, ifu_rsp_data, lsu_rsp_data);
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ifu_fetch();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL fetch_ready: got ifu/lsu=%b want 10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        ifu_addr      = 32'h1234_5678;
        mem_req_ready = 1'b1;
        total++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wmask} !== {1'b1, 32'h8000_0000, 1'b0, 4'h0}) begin
            bad++;
            $display("FAIL fetch_issue: valid=%b addr=%h wen=%b wmask=%h want 1 80000000 0 0",
                     mem_req_valid, mem_addr, mem_wen, mem_wmask);
        end
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h0010_0093;
        total++;
        if ({mem_req_valid, ifu_rsp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL fetch_wait: req_valid/rsp_valid=%b want 00", {mem_req_valid, ifu_rsp_valid});
        end
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        total++;
        if ({ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err} !== {1'b1, 32'h0010_0093, 1'b0}) begin
            bad++;
            $display("FAIL fetch_rsp: valid=%b data=%h err=%b want 1 00100093 0",
                     ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err);
        end
        total++;
        if ({lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err} !== '0) begin
            bad++;
            $display("FAIL fetch_lsu_quiet: valid=%b data=%h err=%b want 0",
                     lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err);
        end
        tick();
        total++;
        if (ifu_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_one_cycle: ifu_rsp_valid=%b want 0", ifu_rsp_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] a;
        logic [31:0] d;
        logic        lw;
        logic        ok;
        do_reset();
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b0;
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL tie_first_grant: ifu/lsu=%b want 01", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        lsu_req_valid = 1'b0;
        mem_serve(32'h1111_1111, a, lw, d, ok);
        total++;
        if ({ok, lw, a, d} !== {1'b1, 1'b1, 32'h8000_1000, 32'h1111_1111}) begin
            bad++;
            $display("FAIL tie_first_txn: ok=%b lsu=%b addr=%h data=%h want 1 1 80001000 11111111", ok, lw, a, d);
        end
        tick();
        #1;
        total++;
        if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
            bad++;
            $display("FAIL tie_second_grant: ifu/lsu=%b want 10", {ifu_req_ready, lsu_req_ready});
        end
        tick();
        ifu_req_valid = 1'b0;
        mem_serve(32'h2222_2222, a, lw, d, ok);
        total++;
        if ({ok, lw, a, d} !== {1'b1, 1'b0, 32'h8000_0004, 32'h2222_2222}) begin
            bad++;
            $display("FAIL tie_second_txn: ok=%b lsu=%b addr=%h data=%h want 1 0 80000004 22222222", ok, lw, a, d);
        end
        tick();
    endtask

    task automatic test_store_backpressure();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_2000;
        lsu_wen       = 1'b1;
        lsu_wdata     = 32'hDEAD_BEEF;
        lsu_wmask     = 4'hF;
        #1;
        total++;
        if (lsu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL store_ready: lsu_req_ready=%b want 1", lsu_req_ready);
        end
        tick();
        lsu_req_valid = 1'b0;
        lsu_addr      = '0;
        lsu_wen       = 1'b0;
        lsu_wdata     = '0;
        lsu_wmask     = '0;
        for (int c = 0; c < 4; c++) begin
            total++;
            if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !==
                {1'b1, 32'h8000_2000, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
                bad++;
                $display("FAIL store_stable[%0d]: valid=%b addr=%h wen=%b wdata=%h wmask=%h want 1 80002000 1 deadbeef f",
                         c, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
            end
            if (c == 3) mem_req_ready = 1'b1;
            tick();
        end
        mem_req_ready = 1'b0;
        total++;
        if ({mem_req_valid, lsu_rsp_valid} !== 2'b00) begin
            bad++;
            $display("FAIL store_wait: req_valid/rsp_valid=%b want 00", {mem_req_valid, lsu_rsp_valid});
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = '0;
        tick();
        mem_rsp_valid = 1'b0;
        total++;
        if ({lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid} !== 3'b100) begin
            bad++;
            $display("FAIL store_rsp: lsu_valid/err ifu_valid=%b want 100", {lsu_rsp_valid, lsu_rsp_err, ifu_rsp_valid});
        end
        tick();
        total++;
        if (lsu_rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL store_one_cycle: lsu_rsp_valid=%b want 0", lsu_rsp_valid);
        end
    endtask

    task automatic test_timeout();
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_4000;
        lsu_wen       = 1'b0;
        tick();
        lsu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({lsu_rsp_valid, ifu_rsp_valid} !== 2'b00) begin
                bad++;
                $display("FAIL timeout_early[%0d]: lsu/ifu rsp_valid=%b want 00", k, {lsu_rsp_valid, ifu_rsp_valid});
            end
            tick();
        end
        total++;
        if ({lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data, ifu_rsp_valid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL timeout_err: valid=%b err=%b data=%h ifu_valid=%b want 1 1 0 0",
                     lsu_rsp_valid, lsu_rsp_err, lsu_rsp_data, ifu_rsp_valid);
        end
        tick();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        total++;
        if ({lsu_rsp_valid, ifu_rsp_valid, mem_req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL late_rsp_dropped: lsu/ifu/mem_req=%b want 000", {lsu_rsp_valid, ifu_rsp_valid, mem_req_valid});
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] a;
        logic [31:0] d;
        logic        lw;
        logic        ok;
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_5000;
        tick();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if ({ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_rsp_valid, lsu_rsp_valid,
             ifu_rsp_err, lsu_rsp_err, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: mem_req_valid=%b ifu_rsp=%b lsu_rsp=%b addr=%h want all 0",
                     mem_req_valid, ifu_rsp_valid, lsu_rsp_valid, mem_addr);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0_BAD0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick();
        total++;
        if ({ifu_rsp_valid, lsu_rsp_valid, mem_req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL rst_mid_no_strobe: ifu/lsu/mem_req=%b want 000", {ifu_rsp_valid, lsu_rsp_valid, mem_req_valid});
        end
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0008;
        tick();
        ifu_req_valid = 1'b0;
        mem_serve(32'hABCD_0001, a, lw, d, ok);
        total++;
        if ({ok, lw, a, d} !== {1'b1, 1'b0, 32'h8000_0008, 32'hABCD_0001}) begin
            bad++;
            $display("FAIL rst_mid_fresh: ok=%b lsu=%b addr=%h data=%h want 1 0 80000008 abcd0001", ok, lw, a, d);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] d;
        logic        lw;
        logic        ok;
        logic        exp_lsu;
        // Last winner before this point is the IFU, so the first tie goes to the LSU.
        ifu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0100;
        lsu_req_valid = 1'b1;
        lsu_addr      = 32'h8000_3000;
        lsu_wen       = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_lsu = (i % 2 == 0);
            #1;
            total++;
            if ({lsu_req_ready, ifu_req_ready} !== {exp_lsu, !exp_lsu}) begin
                bad++;
                $display("FAIL rr_ready[%0d]: lsu/ifu=%b want %b", i, {lsu_req_ready, ifu_req_ready}, {exp_lsu, !exp_lsu});
            end
            tick();
            mem_serve(32'h5000_0000 + i, a, lw, d, ok);
            total++;
            if ({ok, lw, a, d} !== {1'b1, exp_lsu, (exp_lsu ? 32'h8000_3000 : 32'h8000_0100), 32'h5000_0000 + i}) begin
                bad++;
                $display("FAIL rr_txn[%0d]: ok=%b lsu=%b addr=%h data=%h want lsu=%b", i, ok, lw, a, d, exp_lsu);
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifu_fetch();
        test_simultaneous();
        test_store_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
